rom_fetch_unit: RTL and testbench

- Upstream/downstream companion to the 256x64 lookup ROM. Owns the address counter driving the ROM's 8-bit address and captures each 64-bit word the ROM returns.
- Buffers captured words in a small FIFO and presents them to a consumer over a valid/ready handshake.
- Supports redirect (jump) with flush. This is the sequential front end that walks ROM contents.

---
 rtl/rom_pkg.sv | 10 +
 rtl/rom_fetch_unit_if.sv | 10 +
 rtl/fetch_fifo.sv | 40 ++++
 rtl/rom_fetch_unit.sv | 66 ++++++
 tb/tb_rom_fetch_unit.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/rom_pkg.sv
// rom_pkg: shared widths, fetch entry layout and fetch state encoding for the ROM front end.
package rom_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;
  typedef enum logic {FETCH, HALT} fetch_state_t;
endpackage

// File: rtl/rom_fetch_unit_if.sv
// rom_fetch_unit_if: valid/ready stream carrying fetched ROM words and their source addresses.
interface rom_fetch_unit_if;
  import rom_pkg::*;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out;
  logic [ADDR_W-1:0] out_address;
  modport master(output out_valid, out, out_address, input out_ready);
  modport slave(input out_valid, out, out_address, output out_ready);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch entries with flush; head is read straight from storage.
module fetch_fifo
  import rom_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr, rd;
  assign head = mem[rd];
  // Flush only rewinds pointers; stale storage is never visible because out_valid drops.
  always_ff @(posedge clk)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + PW'(1);
      end
      if (pop) rd <= rd + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: walks the lookup ROM, buffers words in a FIFO, supports redirect with flush.
// Optional FETCH_BOUND_EN halts fetching after LIMIT_ADDR until the next redirect.
module rom_fetch_unit
  import rom_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR = 8'h00,
  parameter int                DEPTH      = 2
`ifdef FETCH_BOUND_EN
  , parameter logic [ADDR_W-1:0] LIMIT_ADDR = 8'h3F
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_address,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] rom_data,
  output logic              halted,
  rom_fetch_unit_if.master  o
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0] count;
  logic pop, fire;
  fetch_entry_t din, head;
  assign address = pc;
  assign pop = o.out_valid & o.out_ready;
  // A full FIFO still fetches when it pops in the same cycle, so streaming has no bubbles.
  assign fire = enable & ~halted & ~redirect_valid & ((count < CW'(DEPTH)) | pop);
  assign din = '{addr: pc, data: rom_data};
  assign o.out_valid = count != '0;
  assign o.out = head.data;
  assign o.out_address = head.addr;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(fire),
    .pop(pop),
    .flush(redirect_valid),
    .din(din),
    .count(count),
    .head(head)
  );
`ifdef FETCH_BOUND_EN
  fetch_state_t state;
  always_ff @(posedge clk)
    if (reset) begin
      pc <= START_ADDR;
      state <= FETCH;
    end else if (redirect_valid) begin
      pc <= redirect_address;
      state <= FETCH;
    end else if (fire) begin
      state <= pc == LIMIT_ADDR ? HALT : FETCH;
      pc <= pc == LIMIT_ADDR ? pc : pc + 8'd1;
    end
  assign halted = state == HALT;
`else
  always_ff @(posedge clk)
    if (reset) pc <= START_ADDR;
    else if (redirect_valid) pc <= redirect_address;
    else if (fire) pc <= pc + 8'd1;
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb_rom_fetch_unit: directed and random stimulus against a queue-based model of the fetch stream.
module tb_rom_fetch_unit;
  import rom_pkg::*;
  localparam int DEPTH = 2;
  localparam logic [7:0] START = 8'h00;
  localparam logic [7:0] LIMIT = 8'h3F;
`ifdef FETCH_BOUND_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, enable, redirect_valid, halted;
  logic [7:0] redirect_address, address;
  logic [63:0] rom_data;
  int checks = 0;
  int errors = 0;
  logic [71:0] q[$];
  logic [7:0] m_pc;
  logic m_halt;
  rom_fetch_unit_if bus();
  rom_fetch_unit #(.START_ADDR(START), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .redirect_valid(redirect_valid),
    .redirect_address(redirect_address),
    .address(address),
    .rom_data(rom_data),
    .halted(halted),
    .o(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] rom(input logic [7:0] a);
    return a < 8'h40 ? {56'h0, a} : 64'h0;
  endfunction
  assign rom_data = rom(address);
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic en, input logic rdy, input logic rv, input logic [7:0] ra);
    logic pop, fire;
    reset = r;
    enable = en;
    bus.out_ready = rdy;
    redirect_valid = rv;
    redirect_address = ra;
    pop = q.size() != 0 && rdy;
    fire = en && !m_halt && !rv && (q.size() < DEPTH || pop);
    if (r) begin
      q.delete();
      m_pc = START;
      m_halt = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (rv) begin
        q.delete();
        m_pc = ra;
        m_halt = 1'b0;
      end else if (fire) begin
        q.push_back({m_pc, rom(m_pc)});
        if (BOUND && m_pc == LIMIT) m_halt = 1'b1;
        else m_pc++;
      end
    end
    @(posedge clk);
    #1;
    chk("address", 72'(address), 72'(m_pc));
    chk("halted", 72'(halted), 72'(m_halt));
    chk("out_valid", 72'(bus.out_valid), 72'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_address", 72'(bus.out_address), 72'(q[0][71:64]));
      chk("out", 72'(bus.out), 72'(q[0][63:0]));
    end
  endtask
  initial begin
    logic [7:0] wa [4];
    logic [63:0] wd [4];
    wa = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    wd = '{64'h0, 64'h0, 64'h0, 64'h1};
    cyc(1, 0, 1, 0, 8'h00);
    chk("rst_address", 72'(address), 72'(START));
    chk("rst_valid", 72'(bus.out_valid), 72'h0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 1, 0, 8'h00);
      chk("seq_head", 72'(bus.out_address), 72'(i));
      chk("seq_pc", 72'(address), 72'(i + 1));
    end
    cyc(1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 8'h00);
    chk("stall_address", 72'(address), 72'h02);
    chk("stall_head", 72'(bus.out_address), 72'h00);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 1, 1, 0, 8'h00);
      chk("drain_head", 72'(bus.out_address), 72'(i));
    end
    cyc(1, 0, 1, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 1, 1, 8'h3E);
    chk("redir_flush", 72'(bus.out_valid), 72'h0);
    cyc(0, 1, 1, 0, 8'h00);
    chk("redir_w0", {bus.out_address, bus.out}, {8'h3E, 64'h3E});
    cyc(0, 1, 1, 0, 8'h00);
    chk("redir_w1", {bus.out_address, bus.out}, {8'h3F, 64'h3F});
`ifndef FETCH_BOUND_EN
    cyc(0, 1, 1, 1, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, 8'h00);
      chk("wrap", {bus.out_address, bus.out}, {wa[i], wd[i]});
      chk("wrap_halted", 72'(halted), 72'h0);
    end
`else
    cyc(0, 1, 1, 1, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, 8'h00);
      chk("bound_run", {bus.out_address, bus.out}, {8'h3C + 8'(i), 64'h3C + 64'(i)});
    end
    chk("bound_halted", 72'(halted), 72'h1);
    cyc(0, 1, 1, 0, 8'h00);
    cyc(0, 1, 1, 0, 8'h00);
    chk("bound_frozen", 72'(address), 72'h3F);
    chk("bound_drained", 72'(bus.out_valid), 72'h0);
    cyc(0, 1, 1, 1, 8'h10);
    chk("bound_clear", 72'(halted), 72'h0);
    cyc(0, 1, 1, 0, 8'h00);
    chk("bound_resume", {bus.out_address, bus.out}, {8'h10, 64'h10});
`endif
    cyc(1, 0, 1, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(1, 1, 1, 1, 8'h55);
    chk("mid_rst_valid", 72'(bus.out_valid), 72'h0);
    chk("mid_rst_out", 72'(bus.out), 72'h0);
    chk("mid_rst_oaddr", 72'(bus.out_address), 72'h0);
    chk("mid_rst_addr", 72'(address), 72'(START));
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 11) == 0, 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
